ifu: RTL and testbench
======================

# ifu

Instruction fetch unit: owns the program counter and issues one word-aligned fetch request at a time to instruction memory over a valid/ready request channel. It accepts the response and presents the instruction with its PC to the decode stage (`idu`) over a valid/ready handshake. It sits directly upstream of decode and replaces the free-running `pc_reg` plus externally supplied `inst`. It also supports branch/jump redirects, a halt request (from `ebreak`), and a count of delivered instructions.

## Interface
- `RESET_PC`, 32'h8000_0000: PC loaded at reset; bits [1:0] must be 0.
- `CNT_W`, 64: width of the delivered-instruction counter.

- `clk`, in, 1: single clock; all state updates on rising edge.
- `rstn`, in, 1: reset; synchronous, active-low.
- `mem_req_valid`, out, 1: fetch request valid.
- `mem_req_ready`, in, 1: memory accepts the request this cycle.
- `mem_req_addr`, out, 32: fetch address; always equals current `pc`, bits [1:0] = 0.
- `mem_rsp_valid`, in, 1: response valid; exactly one per accepted request, earliest the cycle after acceptance.
- `mem_rsp_data`, in, 32: instruction word.
- `mem_rsp_err`, in, 1: access fault for this response.
- `inst_valid`, out, 1: instruction available to decode.
- `inst_ready`, in, 1: decode consumes the instruction this cycle.
- `inst`, out, 32: instruction word.
- `inst_pc`, out, 32: PC of `inst`.
- `inst_err`, out, 1: fetch fault flag travelling with `inst`.
- `redirect_valid`, in, 1: load a new PC (branch/jump).
- `redirect_pc`, in, 32: new PC; bits [1:0] are forced to 0.
- `halt_req`, in, 1: stop fetching after the current handoff.
- `halted`, out, 1: the unit is in HALT.
- `fetch_cnt`, out, CNT_W: number of completed `inst` handshakes since reset.

## Operation
- State machine states: REQ, WAIT, OUT, HALT. Internal registers: `pc`, `kill`.
- REQ:
  - `mem_req_valid` = 1 unless `redirect_valid` is high; the suppression is combinational.
  - On `redirect_valid`: `pc` <= `redirect_pc & ~3`; stay in REQ.
  - Otherwise, on `mem_req_ready`: go to WAIT with `kill` = 0.
- WAIT: `mem_req_valid` = 0.
  - `redirect_valid` without `mem_rsp_valid`: `pc` <= redirect target; `kill` <= 1; stay in WAIT.
  - `mem_rsp_valid` with `kill` = 1, or with `redirect_valid` in the same cycle: discard the response, clear `kill`, go to REQ. A same-cycle redirect also loads `pc`.
  - `mem_rsp_valid` otherwise: latch `inst` <= data, `inst_pc` <= `pc`, `inst_err` <= err; go to OUT.
- OUT:
  - `inst_valid` = 1; `inst`, `inst_pc` and `inst_err` are held stable until the handshake completes.
  - Handshake (`inst_ready`) without redirect: `pc` <= `pc` + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); `fetch_cnt` += 1; go to HALT if `halt_req`, else REQ.
  - Handshake with `redirect_valid`: transfer counts (`fetch_cnt` += 1); `pc` <= redirect target; go to HALT if `halt_req`, else REQ.
  - `redirect_valid` without `inst_ready`: instruction dropped; `pc` <= redirect target; go to REQ.
- HALT: no requests, `inst_valid` = 0, `halted` = 1. Only reset leaves HALT; `redirect_valid` is ignored.
- `halt_req` is sampled only at an OUT handshake.
- `inst_err` does not stop fetching; decode/trap logic handles it.
- `fetch_cnt` wraps modulo 2^CNT_W.

## Timing
- Reset values (cycle after `rstn` sampled low):
  - state = REQ; `pc` = `RESET_PC`; `kill` = 0.
  - `inst` = 0; `inst_pc` = `RESET_PC`; `inst_err` = 0.
  - `fetch_cnt` = 0; `halted` = 0.
  - `mem_req_valid` = 0 and `inst_valid` = 0 while `rstn` = 0.
- First request: `mem_req_valid` = 1 in the first cycle with `rstn` = 1.
- Best-case throughput: one instruction per 3 cycles. Request accepted at T (REQ), response at T+1 (WAIT), `inst_valid` at T+2 (OUT), handshake at T+2, next request at T+3.
- `inst_valid` rises exactly one cycle after the accepted response; there is no combinational path from `mem_rsp_*` to `inst_*`.
- Only outstanding fetch is 1; `mem_req_valid` never asserts in WAIT or OUT.
- Reset mid-operation (any state, including WAIT with a response pending): the unit returns to reset values. A response arriving in the first post-reset cycle is a protocol violation, which the integration prevents by resetting memory together with the IFU.

## Test plan
- Reset, then memory with zero-wait accept and 1-cycle response; decode always ready -> `mem_req_addr` 0x8000_0000, 0x8000_0004, 0x8000_0008 each 3 cycles apart; `fetch_cnt` = 3 after the third handshake.
- Decode holds `inst_ready` = 0 for 5 cycles in OUT -> `inst`/`inst_pc` stable, no new request issued; release -> `pc` advances by 4, `fetch_cnt` += 1.
- `redirect_valid` with `redirect_pc` = 0x8000_0103 while in WAIT; response arrives 2 cycles later -> response discarded, `inst_valid` never rises for it, next `mem_req_addr` = 0x8000_0100.
- Redirect to 0x8000_0040 in OUT with `inst_ready` = 0 -> `inst_valid` falls next cycle, `fetch_cnt` unchanged, next request to 0x8000_0040; repeat with `inst_ready` = 1 -> same address, `fetch_cnt` += 1.
- Response with `mem_rsp_err` = 1 -> `inst_err` = 1 in OUT; after the handshake, fetching continues at `pc` + 4 with `inst_err` = 0 on the next good response.
- `halt_req` = 1 at an OUT handshake -> `halted` = 1 next cycle, `mem_req_valid` stays 0 for 20 cycles despite `redirect_valid`; `rstn` low for 1 cycle -> request to `RESET_PC`, `fetch_cnt` = 0.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to
// instruction memory and hands each returned word, with its PC and fault
// flag, to decode over a valid/ready handshake. Handles redirects, halt and
// counts delivered instructions.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rstn,
  // instruction memory request channel
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  // instruction memory response channel
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  input  logic             mem_rsp_err,
  // decode handoff
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic             inst_err,
  // control
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             halt_req,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ,   // request the word at pc
    S_WAIT,  // one request outstanding, waiting for its response
    S_OUT,   // instruction presented to decode
    S_HALT   // parked until reset
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic        kill, kill_d;      // outstanding response belongs to a stale pc
  logic        rsp_take;          // capture the response into the inst registers
  logic        cnt_inc;           // decode handshake completed this cycle
  logic [31:0] redirect_tgt;

  // Redirect targets are always word aligned.
  assign redirect_tgt = redirect_pc & ~32'h3;
  assign mem_req_addr = pc;
  assign halted       = (state == S_HALT);

  // Next-state, next-pc and handshake outputs of the fetch FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d       = state;
    pc_d          = pc;
    kill_d        = kill;
    rsp_take      = 1'b0;
    cnt_inc       = 1'b0;
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;

    unique case (state)
      S_REQ: begin
        // A redirect withdraws the request in the same cycle.
        mem_req_valid = !redirect_valid;
        if (redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (mem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = 1'b0;
        end
      end

      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (kill || redirect_valid) begin
            // Response is for a pc that has been abandoned: drop it.
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = redirect_tgt;
          end else begin
            rsp_take = 1'b1;
            state_d  = S_OUT;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
      end

      S_OUT: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          // The transfer counts even when a redirect arrives with it.
          cnt_inc = 1'b1;
          pc_d    = redirect_valid ? redirect_tgt : pc + 32'd4;
          state_d = halt_req ? S_HALT : S_REQ;
        end else if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end
      end

      S_HALT: begin
        // Only reset leaves HALT; redirects are ignored.
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // No request or instruction is offered while reset is asserted.
    if (!rstn) begin
      mem_req_valid = 1'b0;
      inst_valid    = 1'b0;
    end
  end

  // State, pc, captured instruction and delivery counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstn) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      kill      <= 1'b0;
      inst      <= '0;
      inst_pc   <= RESET_PC;
      inst_err  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      kill  <= kill_d;
      if (rsp_take) begin
        inst     <= mem_rsp_data;
        inst_pc  <= pc;
        inst_err <= mem_rsp_err;
      end
      if (cnt_inc) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a behavioural instruction memory, a
// scoreboard of expected requests and presented instructions, and a directed
// cycle-by-cycle stimulus sequence.
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CNT_W    = 64;

  logic             clk;
  logic             rstn;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [31:0]      mem_req_addr;
  logic             mem_rsp_valid;
  logic [31:0]      mem_rsp_data;
  logic             mem_rsp_err;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic             inst_err;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             halt_req;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;

  ifu #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .fetch_cnt      (fetch_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_inst_t;

  exp_inst_t   exp_inst_q[$];
  logic [31:0] exp_req_q[$];
  int          acc_cyc[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          rsp_delay;
  logic [31:0] err_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic exp_inst(input logic [31:0] pc, input logic err);
    exp_inst_t e;
    e.data = mem_word(pc);
    e.pc   = pc;
    e.err  = err;
    exp_inst_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Memory model: accepts requests, checks their address, answers after
  // rsp_delay cycles with one response.
  initial begin
    logic        acc;
    logic        pend;
    int          cd;
    logic [31:0] hold_addr;
    logic [31:0] paddr;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    pend          = 1'b0;
    cd            = 0;
    hold_addr     = '0;
    paddr         = '0;
    forever begin
      @(negedge clk);
      acc = rstn && mem_req_valid && mem_req_ready;
      if (acc) begin
        hold_addr = mem_req_addr;
        acc_cyc.push_back(cyc);
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL req_unexpected: got addr %h expected no request (cycle %0d)",
                   mem_req_addr, cyc);
        end else begin
          check("req_addr", {32'h0, mem_req_addr}, {32'h0, exp_req_q.pop_front()});
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        pend  = 1'b1;
        cd    = rsp_delay;
        paddr = hold_addr;
      end
      mem_rsp_valid = 1'b0;
      if (pend) begin
        if (cd <= 1) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(paddr);
          mem_rsp_err   = (paddr == err_addr);
          pend          = 1'b0;
        end else begin
          cd--;
        end
      end
    end
  end

  // Monitor: every new presentation pops the scoreboard; while held, the
  // presented fields must not change.
  initial begin
    logic        prev_valid;
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    logic        h_err;
    exp_inst_t   e;
    prev_valid = 1'b0;
    h_inst     = '0;
    h_pc       = '0;
    h_err      = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && inst_valid && !prev_valid) begin
        if (exp_inst_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL inst_unexpected: got pc %h inst %h expected no instruction (cycle %0d)",
                   inst_pc, inst, cyc);
        end else begin
          e = exp_inst_q.pop_front();
          check("inst_data", {32'h0, inst},    {32'h0, e.data});
          check("inst_pc",   {32'h0, inst_pc}, {32'h0, e.pc});
          check("inst_err",  {63'h0, inst_err}, {63'h0, e.err});
        end
        h_inst = inst;
        h_pc   = inst_pc;
        h_err  = inst_err;
      end else if (rstn && inst_valid) begin
        check("inst_stable", {inst_pc, inst}, {h_pc, h_inst});
        check("err_stable",  {63'h0, inst_err}, {63'h0, h_err});
      end
      prev_valid = rstn && inst_valid;
    end
  end

  // Directed stimulus; Cn marks the n-th cycle after reset release.
  initial begin
    rstn           = 1'b0;
    mem_req_ready  = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    rsp_delay      = 1;
    err_addr       = 32'h0000_0001;

    // Reset state
    tick();
    tick();
    neg();
    check("rst_req_valid",  {63'h0, mem_req_valid}, 64'h0);
    check("rst_inst_valid", {63'h0, inst_valid},    64'h0);
    check("rst_fetch_cnt",  fetch_cnt,              64'h0);
    check("rst_halted",     {63'h0, halted},        64'h0);
    check("rst_inst",       {32'h0, inst},          64'h0);
    check("rst_inst_pc",    {32'h0, inst_pc},       {32'h0, RESET_PC});

    // Sequential fetch, zero-wait memory, decode always ready
    foreach (exp_req_q[i]) exp_req_q.delete(i);
    exp_req_q.push_back(32'h8000_0000);
    exp_req_q.push_back(32'h8000_0004);
    exp_req_q.push_back(32'h8000_0008);
    exp_req_q.push_back(32'h8000_000C);
    exp_inst(32'h8000_0000, 1'b0);
    exp_inst(32'h8000_0004, 1'b0);
    exp_inst(32'h8000_0008, 1'b0);
    exp_inst(32'h8000_000C, 1'b0);
    tick();                               // C0
    rstn = 1'b1;
    neg();
    check("first_req_valid", {63'h0, mem_req_valid}, 64'h1);
    check("first_req_addr",  {32'h0, mem_req_addr},  {32'h0, RESET_PC});
    repeat (9) tick();                    // C9
    inst_ready = 1'b0;
    neg();
    check("cnt_after_3", fetch_cnt, 64'd3);

    // Decode stalls for 5 cycles in OUT
    repeat (2) tick();                    // C11
    check("gap_0_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
    check("gap_1_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    for (int i = 0; i < 5; i++) begin     // C11..C15
      neg();
      check("stall_inst_valid", {63'h0, inst_valid},    64'h1);
      check("stall_no_req",     {63'h0, mem_req_valid}, 64'h0);
      check("stall_cnt",        fetch_cnt,              64'd3);
      tick();
    end
    inst_ready = 1'b1;                    // C16: handshake
    exp_req_q.push_back(32'h8000_0010);
    tick();                               // C17
    rsp_delay = 3;
    neg();
    check("stall_release_cnt",  fetch_cnt,              64'd4);
    check("stall_release_addr", {32'h0, mem_req_addr},  64'h8000_0010);

    // Redirect while WAIT; the stale response arrives two cycles later
    exp_req_q.push_back(32'h8000_0100);
    exp_inst(32'h8000_0100, 1'b0);
    tick();                               // C18
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    neg();
    check("wait_no_req", {63'h0, mem_req_valid}, 64'h0);
    tick();                               // C19
    redirect_valid = 1'b0;
    rsp_delay      = 1;
    tick();                               // C20: stale response
    neg();
    check("stale_no_inst", {63'h0, inst_valid}, 64'h0);
    tick();                               // C21
    neg();
    check("stale_still_no_inst", {63'h0, inst_valid},    64'h0);
    check("redirect_req_valid",  {63'h0, mem_req_valid}, 64'h1);
    check("redirect_req_addr",   {32'h0, mem_req_addr},  64'h8000_0100);

    // Redirect in OUT without handshake: instruction dropped
    exp_req_q.push_back(32'h8000_0104);
    exp_inst(32'h8000_0104, 1'b0);
    repeat (3) tick();                    // C24
    inst_ready = 1'b0;
    neg();
    check("cnt_before_drop", fetch_cnt, 64'd5);
    exp_req_q.push_back(32'h8000_0040);
    exp_inst(32'h8000_0040, 1'b0);
    repeat (2) tick();                    // C26
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    neg();
    check("drop_inst_valid", {63'h0, inst_valid}, 64'h1);
    tick();                               // C27
    redirect_valid = 1'b0;
    neg();
    check("drop_valid_falls", {63'h0, inst_valid},    64'h0);
    check("drop_cnt",         fetch_cnt,              64'd5);
    check("drop_req_addr",    {32'h0, mem_req_addr},  64'h8000_0040);

    // Redirect in OUT together with a handshake: transfer counts
    exp_req_q.push_back(32'h8000_0040);
    exp_inst(32'h8000_0040, 1'b1);
    repeat (2) tick();                    // C29
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    inst_ready     = 1'b1;
    tick();                               // C30
    redirect_valid = 1'b0;
    err_addr       = 32'h8000_0040;
    neg();
    check("hs_redirect_cnt",  fetch_cnt,             64'd6);
    check("hs_redirect_addr", {32'h0, mem_req_addr}, 64'h8000_0040);

    // Faulted fetch, then fetching continues at pc + 4
    exp_req_q.push_back(32'h8000_0044);
    exp_inst(32'h8000_0044, 1'b0);
    repeat (2) tick();                    // C32
    neg();
    check("err_flag_set", {63'h0, inst_err}, 64'h1);
    repeat (3) tick();                    // C35: handshake with halt
    halt_req = 1'b1;
    neg();
    check("err_flag_clear", {63'h0, inst_err}, 64'h0);
    check("after_err_pc",   {32'h0, inst_pc},  64'h8000_0044);

    // Halt: no requests for 20 cycles despite redirects
    tick();                               // C36
    halt_req = 1'b0;
    neg();
    check("halted_set", {63'h0, halted}, 64'h1);
    check("halt_cnt",   fetch_cnt,       64'd8);
    for (int i = 0; i < 20; i++) begin
      tick();
      redirect_valid = i[0];
      redirect_pc    = 32'h8000_0200;
      neg();
      check("halt_no_req",  {63'h0, mem_req_valid}, 64'h0);
      check("halt_no_inst", {63'h0, inst_valid},    64'h0);
    end

    // One-cycle reset leaves HALT
    tick();
    redirect_valid = 1'b0;
    rstn           = 1'b0;
    neg();
    check("in_rst_no_req", {63'h0, mem_req_valid}, 64'h0);
    exp_req_q.push_back(RESET_PC);
    exp_inst(RESET_PC, 1'b0);
    tick();
    rstn       = 1'b1;
    inst_ready = 1'b0;
    neg();
    check("rerst_req_valid", {63'h0, mem_req_valid}, 64'h1);
    check("rerst_req_addr",  {32'h0, mem_req_addr},  {32'h0, RESET_PC});
    check("rerst_cnt",       fetch_cnt,              64'h0);
    check("rerst_halted",    {63'h0, halted},        64'h0);
    repeat (4) tick();
    neg();
    check("rerst_inst_valid", {63'h0, inst_valid}, 64'h1);
    check("rerst_inst_pc",    {32'h0, inst_pc},    {32'h0, RESET_PC});

    check("req_q_drained",  64'(exp_req_q.size()),  64'h0);
    check("inst_q_drained", 64'(exp_inst_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
